// File: rtl/sd_ddr_arb.sv
// sd_ddr_arb: round-robin srdy/drdy arbiter with bounded bursts onto one registered output.
// Build option SD_DDR_ARB_LOCK_EN adds c_lock to hold a grant across multi-word packets.
module sd_ddr_arb #(
  parameter int unsigned width     = 16,
  parameter int unsigned inputs    = 4,
  parameter int unsigned max_burst = 8,
  parameter int unsigned cw        = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
`ifdef SD_DDR_ARB_LOCK_EN
  input  logic [inputs-1:0]       c_lock,
`endif
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic [cw-1:0]           p_chan
);

  localparam int unsigned     CntW     = $clog2(max_burst) + 1;
  localparam logic [CntW-1:0] LastCnt  = CntW'(max_burst - 1);
  localparam logic [cw-1:0]   LastChan = cw'(inputs - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [cw-1:0]   grant_q, grant_d;
  logic [cw-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            p_srdy_q;
  logic [width-1:0] p_data_q;
  logic [cw-1:0]   p_chan_q;

  logic              space, g_srdy, xfer, lock_g, release_burst;
  logic              found;
  logic [cw-1:0]     winner, arb_base, idx;
  logic [inputs-1:0] arb_req;

  assign space  = !p_srdy_q | p_drdy;
  assign g_srdy = c_srdy[grant_q];
  assign xfer   = (state_q == StBurst) & space & g_srdy;

`ifdef SD_DDR_ARB_LOCK_EN
  assign lock_g = c_lock[grant_q];
`else
  assign lock_g = 1'b0;
`endif

  // A locked grant ignores the burst limit; only srdy dropping or an unlocked word releases it.
  assign release_burst = (xfer & (count_q >= LastCnt) & !lock_g) | !g_srdy;

  // In BURST the search starts after the current grant with its own request masked,
  // which is the same as searching from the pointer value it is about to take.
  always_comb begin
    arb_base = (state_q == StBurst) ? grant_q : ptr_q;
    arb_req  = c_srdy;
    if (state_q == StBurst) arb_req[grant_q] = 1'b0;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= inputs; i++) begin
      idx = cw'((32'(arb_base) + i) % inputs);
      if (!found && arb_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    c_drdy = '0;
    if (state_q == StBurst && space) c_drdy[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = winner;
          count_d = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (release_burst) begin
          ptr_d = grant_q;
          if (found) begin
            grant_d = winner;
            count_d = '0;
          end else if (g_srdy) begin
            count_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (xfer && count_q != LastCnt) begin
          count_d = count_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      ptr_q    <= LastChan;
      count_q  <= '0;
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
      p_chan_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (xfer) begin
        p_data_q <= c_data[32'(grant_q) * width +: width];
        p_chan_q <= grant_q;
        p_srdy_q <= 1'b1;
      end else if (p_drdy) begin
        p_srdy_q <= 1'b0;
      end
    end
  end

  assign p_srdy = p_srdy_q;
  assign p_data = p_data_q;
  assign p_chan = p_chan_q;

endmodule

// File: tb/tb_sd_ddr_arb.sv
// Directed self-checking bench for sd_ddr_arb with default parameters.
// The c_lock scenario runs only when SD_DDR_ARB_LOCK_EN is defined.
module tb_sd_ddr_arb;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   c_srdy;
  logic [N-1:0]   c_drdy;
  logic [N*W-1:0] c_data;
  logic           p_srdy;
  logic           p_drdy;
  logic [W-1:0]   p_data;
  logic [1:0]     p_chan;
`ifdef SD_DDR_ARB_LOCK_EN
  logic [N-1:0]   c_lock;
`endif

  int checks   = 0;
  int failures = 0;
  int sent[N];
  int rx;
  logic         pre_srdy, pre_pdrdy;
  logic [N-1:0] pre_cdrdy;
  logic [W-1:0] pre_data;
  logic         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  sd_ddr_arb dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
`ifdef SD_DDR_ARB_LOCK_EN
    .c_lock (c_lock),
`endif
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data),
    .p_chan (p_chan)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel n presents {n, word index} so order and origin are both visible.
  task automatic build_data();
    for (int n = 0; n < N; n++) c_data[n*W +: W] = 16'(n * 4096 + sent[n]);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One clock: capture handshake state just before the edge, advance the sources after it.
  task automatic step();
    logic [N-1:0] acc;
    #1;
    acc       = c_drdy & c_srdy;
    pre_cdrdy = c_drdy;
    pre_srdy  = p_srdy;
    pre_pdrdy = p_drdy;
    pre_data  = p_data;
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) if (acc[n]) sent[n]++;
    build_data();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    c_srdy = '0;
    p_drdy = 1'b1;
    for (int n = 0; n < N; n++) sent[n] = 0;
    build_data();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    c_srdy = '0;
    p_drdy = 1'b1;
`ifdef SD_DDR_ARB_LOCK_EN
    c_lock = '0;
`endif
    for (int n = 0; n < N; n++) sent[n] = 0;
    build_data();
    @(negedge clk);

    // Reset state, with every requester asking
    c_srdy = 4'hF;
    #1;
    check("rst_p_srdy", 32'(p_srdy), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_p_chan", 32'(p_chan), 32'd0);
    check("rst_c_drdy", 32'(c_drdy), 32'd0);
    c_srdy = '0;
    reset  = 1'b0;
    @(negedge clk);

    // Single word on channel 2
    c_srdy = 4'b0100;
    c_data = '0;
    c_data[2*W +: W] = 16'hA5A5;
    #1;
    check("t1_idle_drdy", 32'(c_drdy), 32'h0);
    tick();
    #1;
    check("t1_grant_drdy", 32'(c_drdy), 32'h4);
    check("t1_no_out_yet", 32'(p_srdy), 32'd0);
    tick();
    c_srdy = '0;
    #1;
    check("t1_p_srdy", 32'(p_srdy), 32'd1);
    check("t1_p_data", 32'(p_data), 32'hA5A5);
    check("t1_p_chan", 32'(p_chan), 32'd2);
    tick();
    #1;
    check("t1_idle_p_srdy", 32'(p_srdy), 32'd0);
    check("t1_idle_c_drdy", 32'(c_drdy), 32'h0);

    // All four requesting: 8-word bursts in rotation, no bubbles
    do_reset();
    c_srdy = 4'hF;
    step();
    for (int k = 0; k < 40; k++) begin
      int ch, ix;
      step();
      ch = (k / 8) % 4;
      ix = (k / 32) * 8 + (k % 8);
      check("t2_p_srdy", 32'(p_srdy), 32'd1);
      check("t2_p_chan", 32'(p_chan), 32'(ch));
      check("t2_p_data", 32'(p_data), 32'(ch * 4096 + ix));
    end

    // Channel 1 streaming with p_drdy pattern 1,0,0,1
    do_reset();
    c_srdy = 4'b0010;
    rx = 0;
    step();
    for (int k = 0; k < 24; k++) begin
      p_drdy = pat[k % 4];
      step();
      check("t3_c_drdy", 32'(pre_cdrdy[1]), 32'(!(pre_srdy && !pre_pdrdy)));
      if (pre_srdy && pre_pdrdy) begin
        check("t3_p_data", 32'(pre_data), 32'(4096 + rx));
        rx++;
      end
    end
    check("t3_no_loss", 32'(sent[1]), 32'(rx + int'(p_srdy)));
    check("t3_moved", 32'(rx > 8), 32'd1);

    // Channel 3 alone, 20 words, regranted at the burst limit without a bubble
    do_reset();
    c_srdy = 4'b1000;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      if (sent[3] == 20) c_srdy = '0;
      check("t4_p_srdy", 32'(p_srdy), 32'd1);
      check("t4_p_chan", 32'(p_chan), 32'd3);
      check("t4_p_data", 32'(p_data), 32'(3 * 4096 + k));
    end
    step();
    check("t4_done_p_srdy", 32'(p_srdy), 32'd0);

    // Channel 0 drops after 3 words while channel 2 waits
    do_reset();
    c_srdy = 4'b0101;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_p_chan0", 32'(p_chan), 32'd0);
      check("t5_p_data0", 32'(p_data), 32'(k));
    end
    c_srdy = 4'b0100;
    step();
    #1;
    check("t5_grant2", 32'(c_drdy), 32'h4);
    check("t5_bubble", 32'(p_srdy), 32'd0);
    step();
    check("t5_p_srdy", 32'(p_srdy), 32'd1);
    check("t5_p_chan2", 32'(p_chan), 32'd2);
    check("t5_p_data2", 32'(p_data), 32'(2 * 4096));

    // Reset mid-burst; afterwards the search restarts above channel 3
    c_srdy = 4'b1101;
    step();
    check("t6_busy", 32'(p_srdy), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_p_srdy", 32'(p_srdy), 32'd0);
    check("t6_c_drdy", 32'(c_drdy), 32'h0);
    check("t6_p_data", 32'(p_data), 32'd0);
    for (int n = 0; n < N; n++) sent[n] = 0;
    build_data();
    tick();
    #1;
    check("t6_c_drdy_held", 32'(c_drdy), 32'h0);
    reset = 1'b0;
    step();
    step();
    check("t6_first_p_srdy", 32'(p_srdy), 32'd1);
    check("t6_first_chan", 32'(p_chan), 32'd0);
    check("t6_first_data", 32'(p_data), 32'd0);

`ifdef SD_DDR_ARB_LOCK_EN
    // Locked 12-word packet on channel 1 while channel 0 requests
    do_reset();
    c_lock = 4'b0010;
    c_srdy = 4'b0010;
    step();
    c_srdy = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      step();
      if (sent[1] == 11) c_lock = '0;
      check("lk_p_srdy", 32'(p_srdy), 32'd1);
      check("lk_p_chan", 32'(p_chan), 32'd1);
      check("lk_p_data", 32'(p_data), 32'(4096 + k));
    end
    c_srdy = 4'b0001;
    step();
    check("lk_next_chan", 32'(p_chan), 32'd0);
    check("lk_next_data", 32'(p_data), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_ddr_arb.md
Name: sd_ddr_arb

Overview:
Round-robin srdy/drdy arbiter that shares one full-width DDR link stream between `inputs` requesters, with bounded bursts.
- Sits upstream of the DDR output converter, or downstream of multiple sd_in_ddr instances.
- Presents a registered output word plus the source channel number.
- Grants are held for up to `max_burst` consecutive transfers to amortise link turnaround.

Parameters:
width, 16, data word width (even, matches DDR link full width)
inputs, 4, number of requesters (2..16)
max_burst, 8, max transfers per grant (1..256)
cw, 2, channel id width; must equal clog2(inputs)

Ports:
clk  input  1  clock, posedge
reset  input  1  asynchronous active-high reset
c_srdy  input  inputs  per-requester source ready
c_drdy  output  inputs  per-requester destination ready, at most one bit high
c_data  input  inputs*width  requester data; channel n at [n*width +: width]
p_srdy  output  1  output valid (registered)
p_drdy  input  1  downstream ready
p_data  output  width  output word (registered)
p_chan  output  cw  source channel of p_data (registered)

Behaviour:
- Reset (async): p_srdy=0, p_data=0, p_chan=0, grant=none, state=IDLE, rr pointer=inputs-1, burst count=0. c_drdy=0 throughout reset.
- Output register:
  - space = !p_srdy | p_drdy.
  - A transfer on channel g occurs when c_srdy[g] & c_drdy[g].
  - On a transfer: p_data<=c_data[g], p_chan<=g, p_srdy<=1.
  - Else if p_drdy: p_srdy<=0, and p_data/p_chan hold.
  - Sustains 1 word/clk.
- c_drdy[g] = (state==BURST) & (grant==g) & space. All other bits are 0. Combinational from p_drdy.
- States: IDLE, BURST.
- IDLE:
  - If any c_srdy, pick the winner: first set bit searching from pointer+1 upward, wrapping.
  - Register grant=winner, count=0, go to BURST.
  - There are no transfers in IDLE, so there is 1 cycle of arbitration latency from the first request.
- BURST, release conditions:
  - A transfer occurs with count==max_burst-1, or
  - c_srdy[grant]==0 in a cycle.
- BURST, on release:
  - pointer<=grant.
  - Re-arbitrate in the same cycle over c_srdy with grant's bit masked.
  - If a winner exists, grant<=winner, count<=0, stay in BURST. This gives no bubble.
  - Else if c_srdy[grant] (burst limit case), regrant the same channel with count<=0.
  - Else go to IDLE.
- BURST, otherwise: count increments on each transfer and holds on stall. A stalled (space=0) granted requester keeps the grant; no timeout.
- A requester dropping c_srdy while stalled is legal only in a cycle with no transfer. It releases the grant per the rule above.
- Fairness: with all inputs requesting continuously and p_drdy=1, the grant sequence is 0,1,2,3,0,…, each for exactly max_burst words.
- max_burst=1: each transfer releases; pure per-word round-robin.
- Count width is clog2(max_burst)+1 bits and never wraps.
- Reset mid-burst: the in-flight p_data is discarded and p_srdy drops immediately.

Optional Feature:
SD_DDR_ARB_LOCK_EN:
- Defined:
  - Adds input c_lock[inputs-1:0].
  - While c_lock[grant]=1, the max_burst limit is ignored and count saturates at max_burst-1.
  - Release occurs only when c_srdy[grant]==0, or on the first transfer with c_lock[grant]==0 once count≥max_burst-1.
  - Used for multi-word packets that must not interleave.
- Undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset, then c_srdy=4'b0100 with data 0xA5A5 for 1 word, p_drdy=1:
  - IDLE→BURST grant=2 after 1 clk.
  - p_srdy=1, p_data=0xA5A5, p_chan=2 on the following clk.
  - Then IDLE.
- All 4 inputs continuously requesting, each sending incrementing words, p_drdy=1:
  - p_chan sequence 0×8, 1×8, 2×8, 3×8, 0×8 with no bubbles after the first word.
  - Data per channel arrives in order.
- Channel 1 streaming with p_drdy toggling 1,0,0,1 per clk:
  - No words lost or duplicated.
  - c_drdy[1] is 0 exactly in cycles where p_srdy=1 and p_drdy=0.
  - count increments only on transfers.
- Channel 3 alone requesting 20 words, max_burst=8:
  - Regranted at words 8 and 16 without a bubble.
  - 20 words output back-to-back with p_chan=3.
- Channel 0 sends 3 words then drops c_srdy while channel 2 is waiting:
  - Grant moves to 2 in the drop cycle.
  - The next output word has p_chan=2.
- Assert reset mid-burst with p_srdy=1:
  - p_srdy=0 and c_drdy=0 immediately.
  - After release, the first grant goes to the lowest requesting channel above pointer=inputs-1, i.e. channel 0 if requesting.
- With SD_DDR_ARB_LOCK_EN defined: channel 1 sends 12 words with c_lock[1]=1 while channel 0 is requesting:
  - All 12 words are output contiguously.
  - Grant moves to 0 only after c_lock drops.
